// File: rtl/spm_product_collector.sv
// spm_product_collector
// Serial-to-parallel output stage of the signed serial-parallel multiplier.
// Collects the product bits arriving LSB first from the carry-save chain,
// presents the complete 2N-bit two's-complement product with a valid/ready
// handshake, and raises a sticky framing-error flag on protocol violations.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   start         single-cycle pulse opening a new product frame
//   bit_in        serial product bit, LSB first
//   bit_valid     qualifies bit_in this cycle
//   product       assembled product, stable while product_valid=1
//   product_valid product holds a complete frame
//   product_ready downstream accepts product while product_valid=1
//   busy          a frame is being collected
//   bit_count     bits captured in the current frame
//   frame_err     sticky protocol-violation flag, cleared by an accepted start
module spm_product_collector #(
  parameter int N = 8,
  localparam int PW = 2 * N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic [PW-1:0]         product,
  output logic                  product_valid,
  input  logic                  product_ready,
  output logic                  busy,
  output logic [$clog2(PW):0]   bit_count,
  output logic                  frame_err
);

  localparam int CW = $clog2(PW) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  localparam logic [CW-1:0] LAST_IDX = CW'(PW - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(PW);

  logic [1:0]    state;
  logic [PW-1:0] shreg;
  logic [PW-1:0] shifted;

  // Bits enter at the top and walk down, so after PW shifts the first bit
  // received sits in bit 0.
  assign shifted = {bit_in, shreg[PW-1:1]};

  // Handshake/status flags are pure functions of the registered state.
  assign product_valid = (state == HOLD);
  assign busy          = (state == COLLECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      product   <= '0;
      bit_count <= '0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= COLLECT;
            shreg     <= '0;
            bit_count <= '0;
            frame_err <= 1'b0;
          end else if (bit_valid) begin
            frame_err <= 1'b1;
          end
        end

        COLLECT: begin
          if (start) begin
            // Abort: a bit arriving with the restart becomes bit 0 of the
            // new frame. This also takes priority over a final bit.
            shreg     <= bit_valid ? {bit_in, {(PW-1){1'b0}}} : '0;
            bit_count <= bit_valid ? CW'(1) : '0;
            frame_err <= 1'b1;
          end else if (bit_valid) begin
            shreg <= shifted;
            if (bit_count == LAST_IDX) begin
              product   <= shifted;
              bit_count <= FULL_CNT;
              state     <= HOLD;
            end else begin
              bit_count <= bit_count + 1'b1;
            end
          end
        end

        HOLD: begin
          if (product_ready) begin
            if (start) begin
              state     <= COLLECT;
              shreg     <= '0;
              bit_count <= '0;
              frame_err <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (start) begin
            frame_err <= 1'b1;
          end
          // A stray bit while holding is an error even alongside a restart.
          if (bit_valid) begin
            frame_err <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_product_collector.sv
module tb_spm_product_collector;

  localparam int PW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          bit_in;
  logic          bit_valid;
  logic [PW-1:0] product;
  logic          product_valid;
  logic          product_ready;
  logic          busy;
  logic [4:0]    bit_count;
  logic          frame_err;

  spm_product_collector #(.N(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .product       (product),
    .product_valid (product_valid),
    .product_ready (product_ready),
    .busy          (busy),
    .bit_count     (bit_count),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            a;
    int            b;
    int            stalls;
    int            hold;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t          vecs [5];
  logic [PW-1:0] exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns just after the next falling edge.
  task automatic cyc(input logic st, input logic bv, input logic bi, input logic rdy);
    start         = st;
    bit_valid     = bv;
    bit_in        = bi;
    product_ready = rdy;
    @(negedge clk);
  endtask

  // Drive bits[from..15] with up to 'stalls' bubbles placed randomly.
  task automatic run_bits(input logic [PW-1:0] bits, input int from, input int stalls,
                          input logic rdy);
    int left = stalls;
    for (int i = from; i < PW; i++) begin
      if (i > 0 && left > 0 && ($urandom_range(0, 2) == 0 || (PW - i) <= left)) begin
        cyc(1'b0, 1'b0, 1'b0, rdy);
        check("stall_count", 32'(bit_count), 32'(i));
        left--;
      end
      cyc(1'b0, 1'b1, bits[i], rdy);
    end
  endtask

  // Scoreboard pop: product must be valid right now.
  task automatic expect_product(input string name);
    logic [PW-1:0] e;
    check({name, "_valid"}, 32'(product_valid), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: got product %0h expected no product", name, product);
    end else begin
      e = exp_q.pop_front();
      check({name, "_product"}, 32'(product), 32'(e));
    end
  endtask

  initial begin
    logic [PW-1:0] bits;

    vecs[0] = '{a:    3, b:    5, stalls: 0, hold: 0, exp: 16'h000F};
    vecs[1] = '{a:   -3, b:    5, stalls: 3, hold: 0, exp: 16'hFFF1};
    vecs[2] = '{a: -128, b: -128, stalls: 0, hold: 5, exp: 16'h4000};
    vecs[3] = '{a:  127, b: -128, stalls: 2, hold: 1, exp: 16'hC080};
    vecs[4] = '{a:    6, b:    6, stalls: 1, hold: 2, exp: 16'h0024};

    rst = 1'b1;
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; product_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_product", 32'(product), 32'd0);
    check("rst_valid", 32'(product_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(bit_count), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      logic rdy;
      rdy  = (vecs[v].hold == 0);
      bits = 16'(vecs[v].a * vecs[v].b);
      cyc(1'b1, 1'b0, 1'b0, rdy);
      check("vec_busy", 32'(busy), 32'd1);
      exp_q.push_back(vecs[v].exp);
      run_bits(bits, 0, vecs[v].stalls, rdy);
      expect_product("vec");
      check("vec_busy_hold", 32'(busy), 32'd0);
      check("vec_count_hold", 32'(bit_count), 32'd16);
      check("vec_err", 32'(frame_err), 32'd0);
      for (int h = 0; h < vecs[v].hold; h++) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_valid", 32'(product_valid), 32'd1);
        check("hold_product", 32'(product), 32'(vecs[v].exp));
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("accept_valid", 32'(product_valid), 32'd0);
    end

    // Mid-frame restart without a bit, then a clean 6*6 frame.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bits = 16'h5A5A;
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, bits[i], 1'b0);
    check("abort_count_pre", 32'(bit_count), 32'd7);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_err", 32'(frame_err), 32'd1);
    check("abort_count", 32'(bit_count), 32'd0);
    exp_q.push_back(16'h0024);
    run_bits(16'h0024, 0, 0, 1'b0);
    expect_product("after_abort");
    check("after_abort_err", 32'(frame_err), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_clears_err", 32'(frame_err), 32'd0);

    // Restart carrying a bit: that bit becomes bit 0 of the new frame.
    bits = 16'h0003;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, bits[0], 1'b0);
    check("restart_bit_count", 32'(bit_count), 32'd1);
    check("restart_bit_err", 32'(frame_err), 32'd1);
    exp_q.push_back(16'h0003);
    run_bits(bits, 1, 0, 1'b0);
    expect_product("restart_bit");

    // Bits and a start while holding without ready are dropped and flagged.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("clean_err", 32'(frame_err), 32'd0);
    exp_q.push_back(16'h000F);
    run_bits(16'h000F, 0, 0, 1'b0);
    expect_product("pre_b2b");
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_start_ignored_valid", 32'(product_valid), 32'd1);
    check("hold_start_err", 32'(frame_err), 32'd1);

    // Back-to-back: start with ready in HOLD goes straight to COLLECT.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("b2b_valid", 32'(product_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_err", 32'(frame_err), 32'd0);
    exp_q.push_back(16'hFFFF);
    run_bits(16'(-1 * 1), 0, 0, 1'b0);
    expect_product("b2b");
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("hold_bit_err", 32'(frame_err), 32'd1);
    check("hold_bit_product", 32'(product), 32'hFFFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Start colliding with the final bit: start wins.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("collide_valid", 32'(product_valid), 32'd0);
    check("collide_count", 32'(bit_count), 32'd1);
    check("collide_err", 32'(frame_err), 32'd1);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("pre_rst_count", 32'(bit_count), 32'd10);
    start = 1'b0; bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(bit_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(product_valid), 32'd0);
    check("arst_product", 32'(product), 32'd0);
    check("arst_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("idle_bit_err", 32'(frame_err), 32'd1);
    check("idle_bit_valid", 32'(product_valid), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("post_rst_err", 32'(frame_err), 32'd0);
    exp_q.push_back(16'h0001);
    run_bits(16'h0001, 0, 0, 1'b1);
    expect_product("post_rst");
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_accept", 32'(product_valid), 32'd0);
    check("idle_keeps_product", 32'(product), 32'h0001);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
